// File: rtl/logic_cmd_fifo_if.sv
// Command and status bundle between the producer/consumer and logic_cmd_fifo.
// The master side pushes {opcode, a, b} and pops the head; the slave side is the FIFO.
interface logic_cmd_fifo_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_SIZE = 2,
  parameter int DEPTH       = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   wr_en_in;
  logic [DATA_WIDTH-1:0]  a_in;
  logic [DATA_WIDTH-1:0]  b_in;
  logic [OPCODE_SIZE-1:0] opcode_in;
  logic                   full_out;
  logic                   rd_en_in;
  logic [DATA_WIDTH-1:0]  a_out;
  logic [DATA_WIDTH-1:0]  b_out;
  logic [OPCODE_SIZE-1:0] opcode_out;
  logic                   valid_out;
  logic                   empty_out;
  logic [CW-1:0]          count_out;
  logic                   overflow_out;
  logic                   underflow_out;

  modport master (
    output wr_en_in, a_in, b_in, opcode_in, rd_en_in,
    input  full_out, a_out, b_out, opcode_out, valid_out, empty_out,
           count_out, overflow_out, underflow_out
  );

  modport slave (
    input  wr_en_in, a_in, b_in, opcode_in, rd_en_in,
    output full_out, a_out, b_out, opcode_out, valid_out, empty_out,
           count_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/logic_cmd_fifo.sv
// First-word-fall-through command FIFO feeding the 8-bit logic unit.
// Head outputs come only from registered storage/pointers and read as zero when empty.
module logic_cmd_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_SIZE = 2,
  parameter int DEPTH       = 4
) (
  input  logic clk,
  input  logic rst,
  logic_cmd_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [OPCODE_SIZE-1:0] op;
    logic [DATA_WIDTH-1:0]  a;
    logic [DATA_WIDTH-1:0]  b;
  } cmd_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  cmd_t w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = bus.rd_en_in & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push  = bus.wr_en_in & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (bus.wr_en_in && !w_push) r_ovf <= 1'b1;
      if (bus.rd_en_in && w_empty) r_unf <= 1'b1;
    end
  end

  // Storage needs no reset: stale entries are masked by the empty decode.
  always_ff @(posedge clk) begin
    if (!rst && w_push)
      r_mem[r_wr_ptr] <= '{op: bus.opcode_in, a: bus.a_in, b: bus.b_in};
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign bus.a_out         = w_head.a;
  assign bus.b_out         = w_head.b;
  assign bus.opcode_out    = w_head.op;
  assign bus.valid_out     = ~w_empty;
  assign bus.empty_out     = w_empty;
  assign bus.full_out      = w_full;
  assign bus.count_out     = r_count;
  assign bus.overflow_out  = r_ovf;
  assign bus.underflow_out = r_unf;
endmodule

// File: tb/tb_logic_cmd_fifo.sv
// Bench for logic_cmd_fifo: directed vector table, wrap/reset sequences, then
// random traffic checked against a queue-based reference model.
module tb_logic_cmd_fifo;
  localparam int DW    = 8;
  localparam int OW    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_cmd_fifo_if #(.DATA_WIDTH(DW), .OPCODE_SIZE(OW), .DEPTH(DEPTH)) bus ();

  logic_cmd_fifo #(.DATA_WIDTH(DW), .OPCODE_SIZE(OW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  typedef struct {
    bit            r, w, rd;
    logic [DW-1:0] a, b;
    logic [OW-1:0] op;
    int            cnt;
    bit            full;
    logic [DW-1:0] ea, eb;
    logic [OW-1:0] eop;
    bit            ovf, unf;
    logic [DW-1:0] y;
  } vec_t;

  cmd_t q[$];
  bit   m_ovf, m_unf;
  int   total = 0;
  int   bad   = 0;

  // Downstream logic unit: OR=00, XOR=01, AND=10, NOT=11.
  function automatic logic [DW-1:0] lu(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a ^ b;
      2'b10:   return a & b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit w, input bit rd, input cmd_t c);
    bit pop_ok, push_ok;
    rst           = r;
    bus.wr_en_in  = w;
    bus.rd_en_in  = rd;
    bus.a_in      = c.a;
    bus.b_in      = c.b;
    bus.opcode_in = c.op;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      pop_ok  = rd && (q.size() != 0);
      push_ok = w && (q.size() < DEPTH || pop_ok);
      if (rd && q.size() == 0) m_unf = 1;
      if (w && !push_ok)       m_ovf = 1;
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(c);
    end
    #1;
  endtask

  task automatic chk_model(string tag);
    cmd_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".count"}, 32'(bus.count_out), 32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.empty_out), 32'(q.size() == 0));
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'(q.size() != 0));
    chk({tag, ".full"},  32'(bus.full_out),  32'(q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(bus.overflow_out),  32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.underflow_out), 32'(m_unf));
    chk({tag, ".a"},     32'(bus.a_out),      32'(h.a));
    chk({tag, ".b"},     32'(bus.b_out),      32'(h.b));
    chk({tag, ".op"},    32'(bus.opcode_out), 32'(h.op));
    chk({tag, ".y"},     32'(lu(bus.opcode_out, bus.a_out, bus.b_out)), 32'(lu(h.op, h.a, h.b)));
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.a  = DW'($urandom);
    c.b  = DW'($urandom);
    c.op = OW'($urandom);
    return c;
  endfunction

  vec_t tv[16];

  initial begin
    cmd_t c;
    string tag;
    int pw, pr;

    //        r w rd a      b      op cnt full ea     eb     eop ovf unf y
    tv[0]  = '{1,0,0,8'h00,8'h00,2'd0, 0, 0, 8'h00,8'h00,2'd0, 0, 0, 8'h00};
    tv[1]  = '{0,1,0,8'hA5,8'h0F,2'd0, 1, 0, 8'hA5,8'h0F,2'd0, 0, 0, 8'hAF};
    tv[2]  = '{0,0,1,8'h00,8'h00,2'd0, 0, 0, 8'h00,8'h00,2'd0, 0, 0, 8'h00};
    tv[3]  = '{0,1,0,8'h3C,8'hF0,2'd0, 1, 0, 8'h3C,8'hF0,2'd0, 0, 0, 8'hFC};
    tv[4]  = '{0,1,0,8'h3C,8'hF0,2'd1, 2, 0, 8'h3C,8'hF0,2'd0, 0, 0, 8'hFC};
    tv[5]  = '{0,1,0,8'h3C,8'hF0,2'd2, 3, 0, 8'h3C,8'hF0,2'd0, 0, 0, 8'hFC};
    tv[6]  = '{0,1,0,8'h3C,8'hF0,2'd3, 4, 1, 8'h3C,8'hF0,2'd0, 0, 0, 8'hFC};
    tv[7]  = '{0,1,0,8'h11,8'h22,2'd1, 4, 1, 8'h3C,8'hF0,2'd0, 1, 0, 8'hFC};
    tv[8]  = '{0,1,1,8'h11,8'h22,2'd1, 4, 1, 8'h3C,8'hF0,2'd1, 1, 0, 8'hCC};
    tv[9]  = '{0,0,1,8'h00,8'h00,2'd0, 3, 0, 8'h3C,8'hF0,2'd2, 1, 0, 8'h30};
    tv[10] = '{0,0,1,8'h00,8'h00,2'd0, 2, 0, 8'h3C,8'hF0,2'd3, 1, 0, 8'hC3};
    tv[11] = '{0,0,1,8'h00,8'h00,2'd0, 1, 0, 8'h11,8'h22,2'd1, 1, 0, 8'h33};
    tv[12] = '{0,0,1,8'h00,8'h00,2'd0, 0, 0, 8'h00,8'h00,2'd0, 1, 0, 8'h00};
    tv[13] = '{0,0,1,8'h00,8'h00,2'd0, 0, 0, 8'h00,8'h00,2'd0, 1, 1, 8'h00};
    tv[14] = '{0,1,1,8'hFF,8'h00,2'd3, 1, 0, 8'hFF,8'h00,2'd3, 1, 1, 8'h00};
    tv[15] = '{1,1,1,8'h12,8'h34,2'd2, 0, 0, 8'h00,8'h00,2'd0, 0, 0, 8'h00};

    rst = 1'b1;
    bus.wr_en_in = 0; bus.rd_en_in = 0;
    bus.a_in = '0; bus.b_in = '0; bus.opcode_in = '0;
    m_ovf = 0; m_unf = 0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      c.a = tv[i].a; c.b = tv[i].b; c.op = tv[i].op;
      step(tv[i].r, tv[i].w, tv[i].rd, c);
      tag = $sformatf("vec%0d", i);
      chk({tag, ".count"}, 32'(bus.count_out), 32'(tv[i].cnt));
      chk({tag, ".full"},  32'(bus.full_out),  32'(tv[i].full));
      chk({tag, ".empty"}, 32'(bus.empty_out), 32'(tv[i].cnt == 0));
      chk({tag, ".valid"}, 32'(bus.valid_out), 32'(tv[i].cnt != 0));
      chk({tag, ".a"},     32'(bus.a_out),      32'(tv[i].ea));
      chk({tag, ".b"},     32'(bus.b_out),      32'(tv[i].eb));
      chk({tag, ".op"},    32'(bus.opcode_out), 32'(tv[i].eop));
      chk({tag, ".ovf"},   32'(bus.overflow_out),  32'(tv[i].ovf));
      chk({tag, ".unf"},   32'(bus.underflow_out), 32'(tv[i].unf));
      chk({tag, ".y"},     32'(lu(bus.opcode_out, bus.a_out, bus.b_out)), 32'(tv[i].y));
    end

    // Wrap: hold count at 2 while 10 push/pop pairs cycle the pointers.
    step(0, 1, 0, rnd_cmd());
    step(0, 1, 0, rnd_cmd());
    chk_model("wrap_fill");
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, rnd_cmd());
      chk_model($sformatf("wrap%0d", i));
    end

    // Fill past full and underflow-free; then reset mid-burst with push+pop asserted.
    for (int i = 0; i < 3; i++) step(0, 1, 0, rnd_cmd());
    chk_model("prerst");
    step(1, 1, 1, rnd_cmd());
    chk_model("midrst");
    chk("midrst.count0", 32'(bus.count_out), 32'd0);
    chk("midrst.ovf0", 32'(bus.overflow_out), 32'd0);
    chk("midrst.unf0", 32'(bus.underflow_out), 32'd0);

    // Random traffic with phase-varying push/pop bias.
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      step($urandom_range(0, 79) == 0,
           $urandom_range(0, 99) < pw,
           $urandom_range(0, 99) < pr,
           rnd_cmd());
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
